// File: rtl/mult_arb_pkg.sv
// rtl/mult_arb_pkg.sv - shared state encodings, defaults and round-robin helper for mult_share_arbiter
package mult_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } arb_state_t;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_WIDTH   = 4;

    function automatic int rr_next(input int id, input int num_req);
        return (id == num_req - 1) ? 0 : id + 1;
    endfunction

endpackage

// File: rtl/mult_seq_core.sv
// rtl/mult_seq_core.sv - sequential shift-add unsigned multiplier, one partial product per cycle
module mult_seq_core #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               busy_q;
    logic [2*WIDTH-1:0] product_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_q   <= '0;
            mplier_q  <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            product_q <= '0;
        end else if (start) begin
            mcand_q   <= {{WIDTH{1'b0}}, a};
            mplier_q  <= b;
            cnt_q     <= '0;
            busy_q    <= 1'b1;
            product_q <= '0;
        end else if (busy_q) begin
            if (mplier_q[0]) begin
                product_q <= product_q + mcand_q;
            end
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + 1'b1;
            if (cnt_q == LAST) begin
                busy_q <= 1'b0;
            end
        end
    end

    // done marks the cycle whose closing edge applies the final partial product
    assign done    = busy_q && (cnt_q == LAST);
    assign busy    = busy_q;
    assign product = product_q;

endmodule

// File: rtl/mult_share_arbiter.sv
// rtl/mult_share_arbiter.sv - round-robin arbiter sharing one shift-add multiplier; MULT_ARB_ZERO_SKIP_EN short-circuits zero operands
module mult_share_arbiter
    import mult_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int WIDTH   = DEF_WIDTH,
    localparam int ID_W   = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
    output logic [2*WIDTH-1:0]       rsp_product
);

    arb_state_t        state_q;
    logic [ID_W-1:0]   rr_ptr_q;
    logic              rsp_valid_q;
    logic [ID_W-1:0]   rsp_id_q;

    logic              gnt_found;
    logic [ID_W-1:0]   gnt_idx;
    logic [WIDTH-1:0]  gnt_a;
    logic [WIDTH-1:0]  gnt_b;
    logic              accept;
    logic              core_busy;
    logic              core_done;

    // first valid requester scanning upward from rr_ptr, wrapping modulo NUM_REQ
    always_comb begin
        int idx;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        idx       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_ptr_q) + k) % NUM_REQ;
            if (!gnt_found && req_valid[idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = ID_W'(idx);
            end
        end
    end

    assign gnt_a  = req_a[int'(gnt_idx)*WIDTH +: WIDTH];
    assign gnt_b  = req_b[int'(gnt_idx)*WIDTH +: WIDTH];
    assign accept = (state_q == ST_IDLE) && gnt_found && !rst;

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    mult_seq_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk     (clk),
        .rst     (rst),
        .start   (accept),
        .a       (gnt_a),
        .b       (gnt_b),
        .busy    (core_busy),
        .done    (core_done),
        .product (rsp_product)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (gnt_found) begin
                        rsp_id_q <= gnt_idx;
`ifdef MULT_ARB_ZERO_SKIP_EN
                        if (gnt_a == '0 || gnt_b == '0) begin
                            state_q     <= ST_DONE;
                            rsp_valid_q <= 1'b1;
                        end else begin
                            state_q <= ST_BUSY;
                        end
`else
                        state_q <= ST_BUSY;
`endif
                    end
                end
                ST_BUSY: begin
                    if (core_done || !core_busy) begin
                        state_q     <= ST_DONE;
                        rsp_valid_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (rsp_ready) begin
                        state_q     <= ST_IDLE;
                        rsp_valid_q <= 1'b0;
                        rr_ptr_q    <= ID_W'(rr_next(int'(rsp_id_q), NUM_REQ));
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    rsp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;

endmodule
